// File: rtl/cfg_loader_pkg.sv
// Shared constants and state encoding for the configuration bitstream loader.
package cfg_loader_pkg;

    localparam int DEF_WORD_WIDTH = 32;
    localparam int DEF_LEN_WIDTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/cfg_loader_word_buf.sv
// One-entry valid/ready holding register used to prefetch the next payload word
// while the current word is being shifted out.
module cfg_word_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             crst_n,
    input  logic             i_flush,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Accept only when empty, so a push and a pop never coincide.
    assign o_in_ready  = !r_valid;
    assign o_out_valid = r_valid;
    assign o_out_data  = r_data;

    always_ff @(posedge clk or negedge crst_n) begin
        if (!crst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_in_valid && o_in_ready) begin
            r_valid <= 1'b1;
            r_data  <= i_in_data;
        end else if (i_out_ready && r_valid) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cfg_loader.sv
// Serialises a length-prefixed host frame MSB-first onto the tile config chain,
// with a one-word prefetch so consecutive payload words shift without a gap.
module cfg_loader
    import cfg_loader_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  crst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WORD_WIDTH-1:0] s_data,
    input  logic                  abort,
    output logic                  cfg_out_start,
    output logic                  cfg_bit_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int IDX_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam int WL_W  = LEN_WIDTH + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_WIDTH - 1);

    state_t                r_state, w_next;
    logic                  r_live;
    logic [WORD_WIDTH-1:0] r_shift, w_shift;
    logic [IDX_W-1:0]      r_bit_idx, w_bit_idx;
    logic [LEN_WIDTH-1:0]  r_remain, w_remain;
    logic [WL_W-1:0]       r_words_left, w_words_left;
    logic                  r_first, w_first;
    logic                  r_err, w_err;

    logic [LEN_WIDTH-1:0]  w_len;
    logic [WL_W-1:0]       w_hdr_words;
    logic                  w_xfer, w_exhaust, w_last_bit;
    logic                  w_buf_in_valid, w_buf_in_ready, w_buf_out_valid, w_buf_pop;
    logic [WORD_WIDTH-1:0] w_buf_out_data;

    assign w_len       = s_data[LEN_WIDTH-1:0];
    assign w_hdr_words = ({1'b0, w_len} + WL_W'(WORD_WIDTH - 1)) / WL_W'(WORD_WIDTH);
    assign w_xfer      = s_valid && s_ready;
    assign w_exhaust   = (r_bit_idx == LAST_IDX);
    assign w_last_bit  = (r_remain <= LEN_WIDTH'(1));

    // Words accepted while shifting go to the prefetch buffer; FETCH loads directly.
    assign w_buf_in_valid = (r_state == ST_SHIFT) && w_xfer;

    cfg_word_buf #(.WIDTH(WORD_WIDTH)) u_buf (
        .clk         (clk),
        .crst_n      (crst_n),
        .i_flush     (abort),
        .i_in_valid  (w_buf_in_valid),
        .o_in_ready  (w_buf_in_ready),
        .i_in_data   (s_data),
        .o_out_valid (w_buf_out_valid),
        .i_out_ready (w_buf_pop),
        .o_out_data  (w_buf_out_data)
    );

    // r_live holds s_ready low until the first edge after reset release.
    always_comb begin
        s_ready = 1'b0;
        if (!abort) begin
            case (r_state)
                ST_IDLE:  s_ready = r_live;
                ST_FETCH: s_ready = !w_buf_out_valid && (r_words_left != '0);
                ST_SHIFT: s_ready = w_buf_in_ready && (r_words_left != '0);
                default:  s_ready = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_next       = r_state;
        w_shift      = r_shift;
        w_bit_idx    = r_bit_idx;
        w_remain     = r_remain;
        w_words_left = r_words_left;
        w_first      = r_first;
        w_err        = 1'b0;
        w_buf_pop    = 1'b0;
        if (abort) begin
            w_next       = ST_IDLE;
            w_bit_idx    = '0;
            w_remain     = '0;
            w_words_left = '0;
            w_first      = 1'b0;
        end else begin
            if (w_xfer && (r_state != ST_IDLE))
                w_words_left = r_words_left - WL_W'(1);
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        if (w_len == '0) begin
                            w_err = 1'b1;
                        end else begin
                            w_next       = ST_FETCH;
                            w_remain     = w_len;
                            w_words_left = w_hdr_words;
                            w_first      = 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    // A word may have landed in the buffer on the edge that entered FETCH.
                    if (w_buf_out_valid) begin
                        w_buf_pop = 1'b1;
                        w_shift   = w_buf_out_data;
                        w_bit_idx = '0;
                        w_next    = ST_SHIFT;
                    end else if (w_xfer) begin
                        w_shift   = s_data;
                        w_bit_idx = '0;
                        w_next    = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    w_first  = 1'b0;
                    w_remain = (r_remain != '0) ? r_remain - LEN_WIDTH'(1) : '0;
                    if (w_last_bit) begin
                        w_next = ST_DONE;
                    end else if (w_exhaust) begin
                        if (w_buf_out_valid) begin
                            w_buf_pop = 1'b1;
                            w_shift   = w_buf_out_data;
                            w_bit_idx = '0;
                        end else begin
                            w_next = ST_FETCH;
                        end
                    end else begin
                        w_shift   = r_shift << 1;
                        w_bit_idx = r_bit_idx + IDX_W'(1);
                    end
                end
                ST_DONE: w_next = ST_IDLE;
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge crst_n) begin
        if (!crst_n) begin
            r_state      <= ST_IDLE;
            r_live       <= 1'b0;
            r_shift      <= '0;
            r_bit_idx    <= '0;
            r_remain     <= '0;
            r_words_left <= '0;
            r_first      <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_live       <= 1'b1;
            r_shift      <= w_shift;
            r_bit_idx    <= w_bit_idx;
            r_remain     <= w_remain;
            r_words_left <= w_words_left;
            r_first      <= w_first;
            r_err        <= w_err;
        end
    end

    assign cfg_bit_out   = (r_state == ST_SHIFT) && r_shift[WORD_WIDTH-1];
    assign cfg_out_start = (r_state == ST_SHIFT) && r_first;
    assign busy          = (r_state != ST_IDLE);
    assign done          = (r_state == ST_DONE);
    assign err           = r_err;

endmodule

// File: tb/tb_cfg_loader.sv
// Bench for cfg_loader: expected serial bits are queued as frames are driven and
// popped by a monitor on every shifting cycle between cfg_out_start and done.
module tb_cfg_loader;

    localparam int W = 32;
    localparam int L = 16;

    logic         clk = 1'b0;
    logic         crst_n = 1'b0;
    logic         s_valid = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] s_data = '0;
    logic         s_ready, cfg_out_start, cfg_bit_out, busy, done, err;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;
    bit exp_q[$];
    bit cap      = 1'b0;
    bit first    = 1'b0;

    cfg_loader #(.WORD_WIDTH(W), .LEN_WIDTH(L)) dut (
        .clk           (clk),
        .crst_n        (crst_n),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .abort         (abort),
        .cfg_out_start (cfg_out_start),
        .cfg_bit_out   (cfg_bit_out),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_bits(input logic [W-1:0] word, input int nb);
        for (int i = 0; i < nb; i++) exp_q.push_back(word[W-1-i]);
    endtask

    task automatic push_zeros(input int nb);
        for (int i = 0; i < nb; i++) exp_q.push_back(1'b0);
    endtask

    // Presents one word until accepted; returns on the negedge after the transfer.
    task automatic send(input logic [W-1:0] d);
        s_valid = 1'b1;
        s_data  = d;
        for (int n = 0; n < 200; n++) begin
            #1;
            if (s_ready) break;
            @(negedge clk);
        end
        chk("send_ready", s_ready, 1);
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 300 && busy; n++) @(negedge clk);
        #1;
        chk("idle", busy, 0);
    endtask

    always @(negedge clk) begin
        if (!cap && cfg_out_start) begin
            cap   = 1'b1;
            first = 1'b1;
        end
        if (cap && busy && !done) begin
            chk("start", cfg_out_start, first);
            first = 1'b0;
            chk("sb_avail", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("bit", cfg_bit_out, exp_q.pop_front());
        end
        if (done) begin
            n_done++;
            chk("sb_drain", exp_q.size(), 0);
            cap = 1'b0;
        end else if (!busy) begin
            cap = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int extra;

        #1;
        chk("rst_outputs", {26'd0, s_ready, cfg_out_start, cfg_bit_out, busy, done, err}, 0);
        @(negedge clk);
        crst_n = 1'b1;
        #1 chk("rst_sready_hold", s_ready, 0);
        @(posedge clk);
        #1 chk("sready_after_edge", s_ready, 1);
        @(negedge clk);

        // N=8 with junk in the header's upper bits
        d0 = n_done;
        push_bits(32'hA5000000, 8);
        send(32'hABCD0008);
        send(32'hA5000000);
        wait_idle();
        chk("n8_done", n_done - d0, 1);

        // N=64, both words early; a third word must never be taken
        d0 = n_done;
        push_bits(32'hFFFFFFFF, 32);
        push_bits(32'h00000001, 32);
        send(32'd64);
        send(32'hFFFFFFFF);
        send(32'h00000001);
        s_valid = 1'b1;
        s_data  = 32'hDEADBEEF;
        extra   = 0;
        for (int n = 0; n < 300; n++) begin
            #1;
            if (!busy) break;
            if (s_ready) extra++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("n64_no_third_word", extra, 0);
        chk("n64_idle", busy, 0);
        chk("n64_done", n_done - d0, 1);

        // N=40, second word arrives late: five FETCH cycles holding 0
        d0 = n_done;
        push_bits(32'h0F0F1234, 32);
        push_zeros(5);
        push_bits(32'hB7FFFFFF, 8);
        send(32'd40);
        send(32'h0F0F1234);
        repeat (36) @(negedge clk);
        send(32'hB7FFFFFF);
        wait_idle();
        chk("n40_done", n_done - d0, 1);

        // zero-length header
        send(32'hFFFF0000);
        #1;
        chk("n0_err", err, 1);
        chk("n0_busy", busy, 0);
        @(negedge clk);
        #1 chk("n0_err_clear", err, 0);

        d0 = n_done;
        push_bits(32'h90000000, 4);
        send(32'd4);
        send(32'h90000000);
        wait_idle();
        chk("n4_after_err_done", n_done - d0, 1);

        // abort at bit 10 of a 32-bit frame
        d0 = n_done;
        push_bits(32'h12345678, 10);
        send(32'd32);
        send(32'h12345678);
        repeat (9) @(negedge clk);
        abort = 1'b1;
        #1 chk("abort_pre_busy", busy, 1);
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("abort_idle", busy, 0);
        chk("abort_bit", cfg_bit_out, 0);
        chk("abort_sb", exp_q.size(), 0);
        abort   = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'd4;
        #1 chk("abort_sready", s_ready, 0);
        @(negedge clk);
        abort   = 1'b0;
        s_valid = 1'b0;
        #1 chk("abort_no_hdr", busy, 0);
        chk("abort_no_done", n_done - d0, 0);

        d0 = n_done;
        push_bits(32'h60000000, 4);
        send(32'd4);
        send(32'h60000000);
        wait_idle();
        chk("n4_after_abort_done", n_done - d0, 1);

        // N=33: final word contributes only its MSB
        d0 = n_done;
        push_bits(32'hCAFEBABE, 32);
        push_bits(32'h80000000, 1);
        send(32'd33);
        send(32'hCAFEBABE);
        send(32'h80000000);
        wait_idle();
        chk("n33_done", n_done - d0, 1);

        // asynchronous reset mid-shift
        d0 = n_done;
        push_bits(32'hFFFFFFFF, 5);
        send(32'd32);
        send(32'hFFFFFFFF);
        repeat (4) @(negedge clk);
        #1 chk("pre_rst_bit", cfg_bit_out, 1);
        #1 crst_n = 1'b0;
        #1 chk("async_rst", {26'd0, s_ready, cfg_out_start, cfg_bit_out, busy, done, err}, 0);
        chk("rst_sb", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        crst_n = 1'b1;
        #1 chk("rst2_sready_hold", s_ready, 0);
        @(posedge clk);
        #1 chk("rst2_sready_up", s_ready, 1);
        chk("rst_no_done", n_done - d0, 0);
        @(negedge clk);

        d0 = n_done;
        push_bits(32'h3C000000, 8);
        send(32'd8);
        send(32'h3C000000);
        wait_idle();
        chk("post_rst_done", n_done - d0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
